// File: rtl/dac_serial_tx_multi_if.sv
// Sample hand-off bus between the equaliser output stage and the DAC serialiser.
// Carries NCH packed samples, the DAC power-down bits, and a valid/ready handshake.
//   master : sample producer (drives In_Data, In_Valid, Pd_Mode; reads In_Ready)
//   slave  : serialiser      (reads In_Data, In_Valid, Pd_Mode; drives In_Ready)
`timescale 1ns/1ps
interface dac_serial_tx_multi_if #(
    parameter int DATA_W = 12,
    parameter int NCH    = 2
);
    logic [NCH*DATA_W-1:0] In_Data;
    logic                  In_Valid;
    logic                  In_Ready;
    logic [1:0]            Pd_Mode;

    modport master (output In_Data, output In_Valid, output Pd_Mode, input In_Ready);
    modport slave  (input In_Data, input In_Valid, input Pd_Mode, output In_Ready);
endinterface

// File: rtl/dac_serial_tx_multi.sv
// Multi-channel serialiser for SPI-style DACs (Pmod DA2 / DAC121S101 class).
// Generates a free-running Sclk and an active-low Sync shared by all channels and
// shifts NCH samples out MSB-first, one data line per channel. A one-deep holding
// buffer behind a valid/ready handshake decouples the producer from frame timing.
// Ports:
//   Clk, Rst    system clock, asynchronous active-high reset
//   in_bus      slave side of the sample bus (In_Data, In_Valid, In_Ready, Pd_Mode)
//   Sclk        serial clock; the DAC samples Data_Out on its falling edge
//   Sync        active-low frame enable
//   Data_Out    serial data, bit k carries channel k
//   Busy        frame in progress or holding buffer occupied
//   Frame_Done  one-Clk pulse on the cycle Sync returns high
`timescale 1ns/1ps
module dac_serial_tx_multi #(
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 16,
    parameter int NCH     = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    dac_serial_tx_multi_if.slave  in_bus,
    output logic                  Sclk,
    output logic                  Sync,
    output logic [NCH-1:0]        Data_Out,
    output logic                  Busy,
    output logic                  Frame_Done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Frame word: zero pad, power-down bits, then the sample; the cast zero-extends.
    function automatic logic [FRAME_W-1:0] build_word(input logic [1:0] pd,
                                                      input logic [DATA_W-1:0] smp);
        build_word = FRAME_W'({pd, smp});
    endfunction

    logic [DIV_W-1:0]        div_r;
    logic                    sclk_r;
    state_t                  state_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [FRAME_W-1:0]      shreg_r [NCH];
    logic                    sync_r;
    logic [NCH-1:0]          data_out_r;
    logic                    done_r;
    logic                    busy_r;
    logic                    ready_r;
    logic                    buf_full_r;
    logic [NCH*DATA_W-1:0]   buf_data_r;
    logic [1:0]              buf_pd_r;

    logic                    div_wrap_s;
    logic                    rise_s;
    logic                    accept_s;
    logic                    drain_s;
    logic                    gap_end_s;
    logic                    buf_full_nx_s;
    logic                    busy_nx_s;
    logic [FRAME_W-1:0]      load_word_s [NCH];

    // Divider wrap and rise-event decode; a rise event is the wrap while Sclk is low.
    always_comb begin
        div_wrap_s = (div_r == DIV_W'(CLK_DIV - 1));
        rise_s     = div_wrap_s && !sclk_r;
    end

    // Handshake, buffer drain and next-cycle Busy.
    always_comb begin
        accept_s  = in_bus.In_Valid && ready_r;
        drain_s   = rise_s && (state_r == ST_IDLE) && buf_full_r;
        gap_end_s = rise_s && (state_r == ST_GAP);
        // A fresh accept wins over a simultaneous drain, so the buffer stays full.
        if (accept_s) begin
            buf_full_nx_s = 1'b1;
        end else if (drain_s) begin
            buf_full_nx_s = 1'b0;
        end else begin
            buf_full_nx_s = buf_full_r;
        end
        case (state_r)
            ST_IDLE:  busy_nx_s = drain_s || buf_full_nx_s;
            ST_SHIFT: busy_nx_s = 1'b1;
            ST_GAP:   busy_nx_s = !gap_end_s || buf_full_nx_s;
            default:  busy_nx_s = 1'b1;
        endcase
    end

    // Per-channel frame words built from the holding buffer.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            load_word_s[k] = build_word(buf_pd_r, buf_data_r[k*DATA_W +: DATA_W]);
        end
    end

    // Free-running Sclk divider; Sclk idles high out of reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_r  <= '0;
            sclk_r <= 1'b1;
        end else if (div_wrap_s) begin
            div_r  <= '0;
            sclk_r <= ~sclk_r;
        end else begin
            div_r  <= div_r + DIV_W'(1);
        end
    end

    // Holding buffer, In_Ready and Busy registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            buf_full_r <= 1'b0;
            buf_data_r <= '0;
            buf_pd_r   <= 2'b00;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                buf_data_r <= in_bus.In_Data;
                buf_pd_r   <= in_bus.Pd_Mode;
            end
            buf_full_r <= buf_full_nx_s;
            ready_r    <= !buf_full_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    // Frame state machine; Sync, Data_Out and state move only on rise events.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= '0;
            sync_r     <= 1'b1;
            data_out_r <= '0;
            done_r     <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                shreg_r[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            if (rise_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (buf_full_r) begin
                            // Present the MSB now; the register holds the remaining bits.
                            for (int k = 0; k < NCH; k++) begin
                                data_out_r[k] <= load_word_s[k][FRAME_W-1];
                                shreg_r[k]    <= {load_word_s[k][FRAME_W-2:0], 1'b0};
                            end
                            sync_r    <= 1'b0;
                            bit_cnt_r <= CNT_W'(FRAME_W - 1);
                            state_r   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (bit_cnt_r != '0) begin
                            for (int k = 0; k < NCH; k++) begin
                                data_out_r[k] <= shreg_r[k][FRAME_W-1];
                                shreg_r[k]    <= {shreg_r[k][FRAME_W-2:0], 1'b0};
                            end
                            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                        end else begin
                            // Bit 0 has been held a full period: close the frame.
                            sync_r     <= 1'b1;
                            data_out_r <= '0;
                            done_r     <= 1'b1;
                            state_r    <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_bus.In_Ready = ready_r;
    assign Sclk            = sclk_r;
    assign Sync            = sync_r;
    assign Data_Out        = data_out_r;
    assign Busy            = busy_r;
    assign Frame_Done      = done_r;

endmodule

// File: tb/tb_dac_serial_tx_multi.sv
// Directed testbench for dac_serial_tx_multi: a default instance (DATA_W=12,
// FRAME_W=16, CLK_DIV=4) and a fast instance (FRAME_W=14, CLK_DIV=1). Line monitors
// record each frame's serial words, Sclk-fall count, start time and Sync-high gap.
`timescale 1ns/1ps
module tb_dac_serial_tx_multi;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    dac_serial_tx_multi_if #(.DATA_W(12), .NCH(2)) if_a ();
    dac_serial_tx_multi_if #(.DATA_W(12), .NCH(2)) if_b ();

    logic       sclk_a, sync_a, busy_a, done_a;
    logic [1:0] dout_a;
    logic       sclk_b, sync_b, busy_b, done_b;
    logic [1:0] dout_b;

    dac_serial_tx_multi #(.DATA_W(12), .FRAME_W(16), .NCH(2), .CLK_DIV(4)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .in_bus(if_a.slave), .Sclk(sclk_a), .Sync(sync_a),
        .Data_Out(dout_a), .Busy(busy_a), .Frame_Done(done_a));

    dac_serial_tx_multi #(.DATA_W(12), .FRAME_W(14), .NCH(2), .CLK_DIV(1)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .in_bus(if_b.slave), .Sclk(sclk_b), .Sync(sync_b),
        .Data_Out(dout_b), .Busy(busy_b), .Frame_Done(done_b));

    int errors = 0;
    int checks = 0;

    // Line monitor, instance A
    logic pa_sclk = 1'b1, pa_sync = 1'b1;
    logic [15:0] sh0_a = '0, sh1_a = '0;
    int nf_a = 0, gap_a = 0, dcnt_a = 0;
    time st_a[$]; int gr_a[$]; int nfq_a[$]; logic [15:0] c0_a[$]; logic [15:0] c1_a[$];

    always @(negedge Clk) begin
        pa_sclk <= sclk_a;
        pa_sync <= sync_a;
        if (done_a) dcnt_a <= dcnt_a + 1;
        if (pa_sync && !sync_a) begin
            st_a.push_back($time); gr_a.push_back(gap_a);
            sh0_a <= '0; sh1_a <= '0; nf_a <= 0;
        end
        if (pa_sclk && !sclk_a && !sync_a) begin
            sh0_a <= {sh0_a[14:0], dout_a[0]}; sh1_a <= {sh1_a[14:0], dout_a[1]};
            nf_a <= nf_a + 1;
        end
        if (!pa_sync && sync_a) begin
            c0_a.push_back(sh0_a); c1_a.push_back(sh1_a); nfq_a.push_back(nf_a);
            gap_a <= (!pa_sclk && sclk_a) ? 1 : 0;
        end else if (!pa_sclk && sclk_a && sync_a) begin
            gap_a <= gap_a + 1;
        end
    end

    // Line monitor, instance B
    logic pb_sclk = 1'b1, pb_sync = 1'b1;
    logic [15:0] sh0_b = '0, sh1_b = '0;
    int nf_b = 0;
    time st_b[$]; int nfq_b[$]; logic [15:0] c0_b[$]; logic [15:0] c1_b[$];

    always @(negedge Clk) begin
        pb_sclk <= sclk_b;
        pb_sync <= sync_b;
        if (pb_sync && !sync_b) begin
            st_b.push_back($time);
            sh0_b <= '0; sh1_b <= '0; nf_b <= 0;
        end
        if (pb_sclk && !sclk_b && !sync_b) begin
            sh0_b <= {sh0_b[14:0], dout_b[0]}; sh1_b <= {sh1_b[14:0], dout_b[1]};
            nf_b <= nf_b + 1;
        end
        if (!pb_sync && sync_b) begin
            c0_b.push_back(sh0_b); c1_b.push_back(sh1_b); nfq_b.push_back(nf_b);
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic send_a(input logic [23:0] d, input logic [1:0] pd, output time t_acc);
        bit ok = 1'b0;
        t_acc = 0;
        if_a.In_Data = d; if_a.Pd_Mode = pd; if_a.In_Valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (if_a.In_Ready) begin
                @(posedge Clk); t_acc = $time; ok = 1'b1;
            end
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_a_accept: no accept within 400 cycles, data %h", d); end
    endtask

    task automatic send_b(input logic [23:0] d, input logic [1:0] pd);
        bit ok = 1'b0;
        if_b.In_Data = d; if_b.Pd_Mode = pd; if_b.In_Valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (if_b.In_Ready) begin
                @(posedge Clk); ok = 1'b1;
            end
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_b_accept: no accept within 200 cycles, data %h", d); end
    endtask

    task automatic test_reset();
        repeat (5) tick();
        checks++;
        if ({sclk_a, sync_a, dout_a, busy_a, done_a, if_a.In_Ready} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_outputs: got sclk,sync,dout,busy,done,rdy=%b want 1100000",
                     {sclk_a, sync_a, dout_a, busy_a, done_a, if_a.In_Ready});
        end
        checks++;
        if ({sclk_b, sync_b, dout_b} !== 4'b1100) begin
            errors++; $display("FAIL reset_outputs_b: got %b want 1100", {sclk_b, sync_b, dout_b});
        end
        Rst = 1'b0;
        tick();
        checks++;
        if (if_a.In_Ready !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL reset_release: got rdy=%b busy=%b want rdy=1 busy=0", if_a.In_Ready, busy_a);
        end
    endtask

    task automatic test_single_frame();
        int nc = c0_a.size(); int ns = st_a.size(); int d0 = dcnt_a; time t;
        send_a({12'h123, 12'hA5C}, 2'b00, t);
        if_a.In_Valid = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_a); end
        for (int i = 0; i < 400 && c0_a.size() <= nc; i++) tick();
        checks++;
        if (c0_a.size() <= nc || st_a.size() <= ns) begin
            errors++; $display("FAIL single_timeout: no complete frame, frames=%0d want %0d", c0_a.size(), nc + 1);
        end else begin
            checks++;
            if (st_a[ns] - t < 15 || st_a[ns] - t > 85) begin
                errors++; $display("FAIL single_latency: got %0t want 15..85", st_a[ns] - t);
            end
            checks++;
            if (c0_a[nc] !== 16'h0A5C) begin errors++; $display("FAIL single_ch0: got %h want 0a5c", c0_a[nc]); end
            checks++;
            if (c1_a[nc] !== 16'h0123) begin errors++; $display("FAIL single_ch1: got %h want 0123", c1_a[nc]); end
            checks++;
            if (nfq_a[nc] !== 16) begin errors++; $display("FAIL single_falls: got %0d want 16", nfq_a[nc]); end
        end
        checks++;
        if (dcnt_a - d0 !== 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", dcnt_a - d0); end
        repeat (12) tick();
        checks++;
        if ({busy_a, sync_a, dout_a} !== 4'b0100) begin
            errors++; $display("FAIL single_idle: got busy,sync,dout=%b want 0100", {busy_a, sync_a, dout_a});
        end
    endtask

    task automatic test_back_to_back();
        int nc = c0_a.size(); int ns = st_a.size(); time t;
        send_a({12'h800, 12'h001}, 2'b00, t);
        send_a({12'h555, 12'h7FF}, 2'b01, t);
        checks++;
        if (if_a.In_Ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b want 0", if_a.In_Ready); end
        send_a({12'h0F0, 12'hC3C}, 2'b10, t);
        if_a.In_Valid = 1'b0;
        for (int i = 0; i < 800 && c0_a.size() < nc + 3; i++) tick();
        checks++;
        if (c0_a.size() < nc + 3 || st_a.size() < ns + 3) begin
            errors++; $display("FAIL b2b_timeout: frames=%0d want %0d", c0_a.size() - nc, 3);
        end else begin
            checks++;
            if (st_a[ns+1] - st_a[ns] !== 1440 || st_a[ns+2] - st_a[ns+1] !== 1440) begin
                errors++; $display("FAIL b2b_spacing: got %0t,%0t want 1440,1440",
                                   st_a[ns+1] - st_a[ns], st_a[ns+2] - st_a[ns+1]);
            end
            checks++;
            if (gr_a[ns+1] !== 2 || gr_a[ns+2] !== 2) begin
                errors++; $display("FAIL b2b_gap_rises: got %0d,%0d want 2,2", gr_a[ns+1], gr_a[ns+2]);
            end
            checks++;
            if ({c0_a[nc], c1_a[nc], c0_a[nc+1], c1_a[nc+1], c0_a[nc+2], c1_a[nc+2]} !==
                {16'h0001, 16'h0800, 16'h17FF, 16'h1555, 16'h2C3C, 16'h20F0}) begin
                errors++; $display("FAIL b2b_data: got %h %h %h %h %h %h want 0001 0800 17ff 1555 2c3c 20f0",
                                   c0_a[nc], c1_a[nc], c0_a[nc+1], c1_a[nc+1], c0_a[nc+2], c1_a[nc+2]);
            end
        end
        repeat (20) tick();
    endtask

    task automatic test_pd_hold();
        int nc = c0_a.size(); time t; logic [15:0] w;
        send_a({12'h000, 12'hFFF}, 2'b11, t);
        // Change the bus while In_Ready is low; none of it may be taken.
        if_a.Pd_Mode = 2'b00; if_a.In_Data = 24'h0; if_a.In_Valid = 1'b1;
        tick();
        if_a.In_Valid = 1'b0;
        for (int i = 0; i < 400 && c0_a.size() <= nc; i++) tick();
        checks++;
        if (c0_a.size() <= nc) begin
            errors++; $display("FAIL pd_timeout: no frame captured");
        end else begin
            w = c0_a[nc];
            checks++;
            if (w[15:12] !== 4'b0011) begin errors++; $display("FAIL pd_top_bits: got %b want 0011", w[15:12]); end
            checks++;
            if (w !== 16'h3FFF || c1_a[nc] !== 16'h3000) begin
                errors++; $display("FAIL pd_words: got %h %h want 3fff 3000", w, c1_a[nc]);
            end
        end
        repeat (20) tick();
    endtask

    task automatic test_reset_midframe();
        int ns = st_a.size(); int d0 = dcnt_a; time t;
        send_a({12'h000, 12'h0FF}, 2'b00, t);
        for (int i = 0; i < 100 && st_a.size() <= ns; i++) tick();
        send_a({12'h111, 12'h222}, 2'b00, t);
        if_a.In_Valid = 1'b0;
        for (int i = 0; i < 200 && nf_a != 8; i++) tick();
        repeat (4) tick();
        checks++;
        if ({sync_a, dout_a[0], busy_a} !== 3'b011) begin
            errors++; $display("FAIL midframe_bit7: got sync,d0,busy=%b want 011", {sync_a, dout_a[0], busy_a});
        end
        Rst = 1'b1;
        #1;
        checks++;
        if ({sclk_a, sync_a, dout_a, busy_a, done_a, if_a.In_Ready} !== 7'b1100000) begin
            errors++; $display("FAIL midframe_abort: got %b want 1100000",
                               {sclk_a, sync_a, dout_a, busy_a, done_a, if_a.In_Ready});
        end
        repeat (3) tick();
        Rst = 1'b0;
        repeat (450) tick();
        checks++;
        if (st_a.size() !== ns + 1) begin
            errors++; $display("FAIL midframe_no_restart: got %0d frame starts want %0d", st_a.size() - ns, 1);
        end
        checks++;
        if (dcnt_a !== d0) begin errors++; $display("FAIL midframe_no_done: got %0d pulses want 0", dcnt_a - d0); end
        checks++;
        if ({if_a.In_Ready, busy_a, sync_a} !== 3'b101) begin
            errors++; $display("FAIL midframe_idle: got rdy,busy,sync=%b want 101", {if_a.In_Ready, busy_a, sync_a});
        end
    endtask

    task automatic test_clkdiv1();
        int nc = c0_b.size(); int ns = st_b.size(); logic s0;
        s0 = sclk_b;
        tick();
        checks++;
        if (sclk_b !== ~s0) begin errors++; $display("FAIL fast_sclk_toggle: got %b want %b", sclk_b, ~s0); end
        send_b({12'h5A5, 12'hABC}, 2'b10);
        send_b({12'h00F, 12'hF00}, 2'b01);
        if_b.In_Valid = 1'b0;
        for (int i = 0; i < 200 && c0_b.size() < nc + 2; i++) tick();
        checks++;
        if (c0_b.size() < nc + 2 || st_b.size() < ns + 2) begin
            errors++; $display("FAIL fast_timeout: frames=%0d want 2", c0_b.size() - nc);
        end else begin
            checks++;
            if ({c0_b[nc], c1_b[nc], c0_b[nc+1], c1_b[nc+1]} !== {16'h2ABC, 16'h25A5, 16'h1F00, 16'h100F}) begin
                errors++; $display("FAIL fast_data: got %h %h %h %h want 2abc 25a5 1f00 100f",
                                   c0_b[nc], c1_b[nc], c0_b[nc+1], c1_b[nc+1]);
            end
            checks++;
            if (nfq_b[nc] !== 14) begin errors++; $display("FAIL fast_falls: got %0d want 14", nfq_b[nc]); end
            checks++;
            if (st_b[ns+1] - st_b[ns] !== 320) begin
                errors++; $display("FAIL fast_spacing: got %0t want 320", st_b[ns+1] - st_b[ns]);
            end
        end
    endtask

    initial begin
        if_a.In_Valid = 1'b0; if_a.In_Data = '0; if_a.Pd_Mode = 2'b00;
        if_b.In_Valid = 1'b0; if_b.In_Data = '0; if_b.Pd_Mode = 2'b00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_pd_hold();
        test_reset_midframe();
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
